// File: rtl/quotient_display_seq.sv
// rtl/quotient_display_seq.sv - divider result capture, serial double-dabble BCD and 4-digit 7-seg scan
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module quotient_display_seq #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    output logic        busy,
    output logic        bcd_valid,
    output logic [15:0] bcd,
    output logic        ovf,
    output logic [6:0]  seg,
    output logic [3:0]  dig
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_ZERO  = 7'b0111111;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state;
    logic [15:0]   shreg;
    logic [19:0]   acc;
    logic [3:0]    bitcnt;

    logic [19:0]   acc_adj;
    logic [19:0]   acc_shift;
    logic          done_now;

    logic [CW-1:0] scnt;
    logic [1:0]    idx;
    logic [1:0]    idx_nx;
    logic [15:0]   bcd_nx;
    logic          ovf_nx;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    seg_nx;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_seg = 7'b0111111;
            4'd1:    digit_seg = 7'b0000110;
            4'd2:    digit_seg = 7'b1011011;
            4'd3:    digit_seg = 7'b1001111;
            4'd4:    digit_seg = 7'b1100110;
            4'd5:    digit_seg = 7'b1101101;
            4'd6:    digit_seg = 7'b1111101;
            4'd7:    digit_seg = 7'b0000111;
            4'd8:    digit_seg = 7'b1111111;
            4'd9:    digit_seg = 7'b1101111;
            default: digit_seg = 7'b0000000;
        endcase
    endfunction

    // Add-3 correction on every nibble before the shift keeps each nibble a valid BCD digit.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 5; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        acc_shift = {acc_adj[18:0], shreg[15]};
        done_now  = (state == SHIFT) && (bitcnt == 4'd15);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            acc       <= '0;
            bitcnt    <= '0;
            busy      <= 1'b0;
            bcd_valid <= 1'b0;
            bcd       <= '0;
            ovf       <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg  <= value;
                        acc    <= '0;
                        bitcnt <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc    <= acc_shift;
                    shreg  <= {shreg[14:0], 1'b0};
                    bitcnt <= bitcnt + 4'd1;
                    if (bitcnt == 4'd15) begin
                        bcd       <= acc_shift[15:0];
                        ovf       <= (acc_shift[19:16] != 4'd0);
                        bcd_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Segments are computed from next-cycle digit index and result so seg, dig and bcd all change together.
    always_comb begin
        idx_nx = (scnt == SCAN_LAST) ? idx + 2'd1 : idx;
        bcd_nx = done_now ? acc_shift[15:0] : bcd;
        ovf_nx = done_now ? (acc_shift[19:16] != 4'd0) : ovf;
        case (idx_nx)
            2'd0:    nib = bcd_nx[3:0];
            2'd1:    nib = bcd_nx[7:4];
            2'd2:    nib = bcd_nx[11:8];
            default: nib = bcd_nx[15:12];
        endcase
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_nx)
            2'd1:    blank = (bcd_nx[15:4] == 12'd0);
            2'd2:    blank = (bcd_nx[15:8] == 8'd0);
            2'd3:    blank = (bcd_nx[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
`endif
        if (ovf_nx)
            seg_nx = SEG_DASH;
        else if (blank)
            seg_nx = SEG_BLANK;
        else
            seg_nx = digit_seg(nib);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scnt <= '0;
            idx  <= 2'd0;
            dig  <= 4'b0001;
            seg  <= SEG_ZERO;
        end else begin
            scnt <= (scnt == SCAN_LAST) ? '0 : scnt + CW'(1);
            idx  <= idx_nx;
            dig  <= 4'b0001 << idx_nx;
            seg  <= seg_nx;
        end
    end

endmodule

// File: tb/tb_quotient_display_seq.sv
// tb/tb_quotient_display_seq.sv - scoreboard bench for quotient_display_seq (SCAN_DIV=4)
module tb_quotient_display_seq;

    localparam int SCAN_DIV = 4;

    localparam logic [6:0] S_0    = 7'b0111111;
    localparam logic [6:0] S_4    = 7'b1100110;
    localparam logic [6:0] S_7    = 7'b0000111;
    localparam logic [6:0] S_8    = 7'b1111111;
    localparam logic [6:0] S_DASH = 7'b1000000;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ     = 7'b0000000;
`else
    localparam logic [6:0] LZ     = S_0;
`endif

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        busy;
    logic        bcd_valid;
    logic [15:0] bcd;
    logic        ovf;
    logic [6:0]  seg;
    logic [3:0]  dig;

    typedef struct {
        logic [15:0] b;
        logic        o;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   valid_cnt = 0;

    quotient_display_seq #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .value     (value),
        .busy      (busy),
        .bcd_valid (bcd_valid),
        .bcd       (bcd),
        .ovf       (ovf),
        .seg       (seg),
        .dig       (dig)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every bcd_valid pulse must match the oldest expected result and its due cycle.
    always @(negedge clk) begin
        if (bcd_valid === 1'b1) begin
            exp_t e;
            valid_cnt++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_bcd_valid: got bcd=%h ovf=%b, required no pulse (cycle %0d)", bcd, ovf, cyc);
            end else begin
                e = sb.pop_front();
                chk("bcd", {16'd0, bcd}, {16'd0, e.b});
                chk("ovf", {31'd0, ovf}, {31'd0, e.o});
                chk("latency", cyc, e.due);
            end
        end
    end

    // Called at a negedge; the following posedge is the load edge.
    task automatic issue(input logic [15:0] v, input logic [15:0] eb, input logic eo);
        exp_t e;
        load    = 1'b1;
        value   = v;
        e.b     = eb;
        e.o     = eo;
        e.due   = cyc + 17;
        sb.push_back(e);
        @(negedge clk);
        load  = 1'b0;
        value = 16'($urandom);
    endtask

    task automatic pulse_ignored(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        @(negedge clk);
        load  = 1'b0;
        value = 16'($urandom);
    endtask

    task automatic check_scan(input string name, input logic [27:0] segs);
        int t;
        t = 0;
        while (dig !== 4'b1000 && t < 40) begin @(negedge clk); t++; end
        chk({name, "_align_hi"}, {31'd0, (t < 40)}, 32'd1);
        t = 0;
        while (dig !== 4'b0001 && t < 10) begin @(negedge clk); t++; end
        chk({name, "_align_lo"}, {31'd0, (t < 10)}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < SCAN_DIV; j++) begin
                chk({name, "_dig"}, {28'd0, dig}, 32'(1 << k));
                chk({name, "_seg"}, {25'd0, seg}, {25'd0, segs[7*k +: 7]});
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int n0;
        int v0;
        rst   = 1'b0;
        load  = 1'b0;
        value = 16'd0;

        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, bcd_valid}, 32'd0);
        chk("rst_bcd", {16'd0, bcd}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_dig", {28'd0, dig}, 32'b0001);
        chk("rst_seg", {25'd0, seg}, {25'd0, S_0});
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        issue(16'd4, 16'h0004, 1'b0);
        chk("busy_after_load", {31'd0, busy}, 32'd1);
        repeat (20) @(negedge clk);
        check_scan("scan4", {LZ, LZ, LZ, S_4});

        issue(16'd870, 16'h0870, 1'b0);
        repeat (20) @(negedge clk);
        check_scan("scan870", {LZ, S_8, S_7, S_0});

        issue(16'd22, 16'h0022, 1'b0);
        repeat (20) @(negedge clk);
        issue(16'd9999, 16'h9999, 1'b0);
        repeat (20) @(negedge clk);
        issue(16'd10000, 16'h0000, 1'b1);
        repeat (20) @(negedge clk);
        check_scan("scan_ovf", {S_DASH, S_DASH, S_DASH, S_DASH});
        issue(16'd65535, 16'h5535, 1'b1);
        repeat (20) @(negedge clk);
        issue(16'd0, 16'h0000, 1'b0);
        repeat (20) @(negedge clk);
        check_scan("scan0", {LZ, LZ, LZ, S_0});

        // Load while busy is dropped; a load in the bcd_valid cycle is taken.
        n0 = cyc + 1;
        issue(16'd1234, 16'h1234, 1'b0);
        while (cyc < n0 + 7) @(negedge clk);
        pulse_ignored(16'd5678);
        while (cyc < n0 + 16) @(negedge clk);
        chk("valid_cycle_busy", {31'd0, busy}, 32'd0);
        issue(16'd42, 16'h0042, 1'b0);
        repeat (25) @(negedge clk);
        chk("busy_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a conversion.
        n0 = cyc + 1;
        issue(16'd1234, 16'h1234, 1'b0);
        while (cyc < n0 + 7) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        v0 = valid_cnt;
        #1;
        chk("amid_busy", {31'd0, busy}, 32'd0);
        chk("amid_bcd", {16'd0, bcd}, 32'd0);
        chk("amid_dig", {28'd0, dig}, 32'b0001);
        chk("amid_seg", {25'd0, seg}, {25'd0, S_0});
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_valid_after_reset", valid_cnt, v0);

        issue(16'd22, 16'h0022, 1'b0);
        repeat (20) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
